// File: rtl/mult_nm_seq_ctrl.sv
// rtl/mult_nm_seq_ctrl.sv - sequential signed N x M shift-add multiplier controller
//
// Takes one operand pair per accepted start. Both operands are converted to
// magnitudes. One N-bit adder performs an iterative shift-add over |B|, LSB
// first. The sign is applied in a final SIGN cycle.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous reset, active-high
//   start  in   1      request, sampled only when busy=0 (IDLE or DONE)
//   A      in   N      signed multiplicand, captured on accepted start
//   B      in   M      signed multiplier, captured on accepted start
//   busy   out  1      high in RUN and SIGN
//   done   out  1      single-cycle pulse, Prod valid in the same cycle
//   Prod   out  N+M    signed product, held until next completion or reset
//
// Optional feature macro: MULT_NM_EARLY_TERM_EN
//   When this macro is defined, RUN ends as soon as the remaining multiplier
//   bits are all zero. SIGN then aligns the accumulator with one barrel shift
//   by the remaining count.

module mult_nm_seq_ctrl #(
    parameter int N = 4,
    parameter int M = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N-1:0]     A,
    input  logic [M-1:0]     B,
    output logic             busy,
    output logic             done,
    output logic [N+M-1:0]   Prod
);

    localparam int CW = $clog2(M + 1);

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t           state, state_next;
    logic [N-1:0]     a_mag;
    logic [M-1:0]     b_reg;
    logic [N+M-1:0]   acc;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic             accept;
    logic             run_last;
    logic [N-1:0]     a_abs;
    logic [M-1:0]     b_abs;
    logic [N:0]       sum;
    logic [N+M-1:0]   acc_shift;
    logic [N+M-1:0]   aligned;
    logic [N+M-1:0]   prod_next;

    // The most negative input maps to 2^(W-1), which is still representable
    // as a W-bit unsigned magnitude.
    assign a_abs = A[N-1] ? (~A + N'(1)) : A;
    assign b_abs = B[M-1] ? (~B + M'(1)) : B;

    // The upper N accumulator bits plus |A| need one extra carry bit. That
    // carry re-enters the top of the accumulator on the right shift.
    assign sum       = {1'b0, acc[N+M-1:M]} + (b_reg[0] ? {1'b0, a_mag} : '0);
    assign acc_shift = {sum, acc[M-1:1]};

`ifdef MULT_NM_EARLY_TERM_EN
    assign run_last = (cnt == CW'(1)) || (b_reg[M-1:1] == '0);
    // cnt is the number of shifts that were skipped. It is zero when every
    // bit was processed.
    assign aligned  = acc >> cnt;
`else
    assign run_last = (cnt == CW'(1));
    assign aligned  = acc;
`endif

    assign prod_next = neg ? (~aligned + (N+M)'(1)) : aligned;

    assign busy   = (state == RUN) || (state == SIGN);
    assign done   = (state == DONE);
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (run_last) state_next = SIGN;
            SIGN:    state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_mag <= '0;
            b_reg <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            Prod  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_mag <= a_abs;
                b_reg <= b_abs;
                neg   <= A[N-1] ^ B[M-1];
                acc   <= '0;
                cnt   <= CW'(M);
            end else if (state == RUN) begin
                acc   <= acc_shift;
                b_reg <= b_reg >> 1;
                cnt   <= cnt - CW'(1);
            end
            // Load Prod when leaving SIGN so that it is valid together with done.
            if (state == SIGN) begin
                Prod <= prod_next;
            end
        end
    end

endmodule

// File: tb/tb_mult_nm_seq_ctrl.sv
// tb/tb_mult_nm_seq_ctrl.sv - directed self-checking bench for mult_nm_seq_ctrl

module tb_mult_nm_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] A;
    logic [4:0] B;
    logic       busy;
    logic       done;
    logic [8:0] Prod;

    int checks = 0;
    int errors = 0;

    mult_nm_seq_ctrl #(.N(4), .M(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Prod  (Prod)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [4:0] b);
`ifdef MULT_NM_EARLY_TERM_EN
        logic [4:0] m;
        int k;
        m = b[4] ? (~b + 5'd1) : b;
        k = 1;
        for (int i = 0; i < 5; i++) if (m[i]) k = i + 1;
        return k + 2;
`else
        return 7;
`endif
    endfunction

    task automatic launch(input logic [3:0] a, input logic [4:0] b);
        start = 1'b1;
        A = a;
        B = b;
        tick();
        start = 1'b0;
        A = 4'hx;
        B = 5'hx;
    endtask

    // Called in cycle c0 after the accept edge. Returns in the done cycle.
    task automatic wait_done(input int c0, input int lat, input logic [8:0] exp_p, input string name);
        int c;
        c = c0;
        while (done !== 1'b1 && c < 40) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy: got %b want 1 at cycle %0d", name, busy, c);
            end
            tick();
            c++;
        end
        checks++;
        if (c !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, c, lat);
        end
        checks++;
        if (Prod !== exp_p) begin
            errors++;
            $display("FAIL %s prod: got %h want %h", name, Prod, exp_p);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b want 0", name, busy);
        end
    endtask

    task automatic check_idle_after(input logic [8:0] exp_p, input string name);
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || Prod !== exp_p) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b prod=%h want 0 0 %h",
                     name, done, busy, Prod, exp_p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        A = 4'd0;
        B = 5'd0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Prod !== 9'h000) begin
            errors++;
            $display("FAIL reset: got busy=%b done=%b prod=%h want 0 0 000", busy, done, Prod);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        launch(4'b0011, 5'b00101);
        wait_done(1, exp_lat(5'b00101), 9'h00F, "basic_3x5");
        check_idle_after(9'h00F, "basic_hold");
        tick();
        checks++;
        if (Prod !== 9'h00F) begin
            errors++;
            $display("FAIL basic_hold2: got %h want 00F", Prod);
        end
    endtask

    task automatic test_vectors();
        logic [3:0] va [8];
        logic [4:0] vb [8];
        logic [8:0] vp [8];
        va[0] = 4'b1000; vb[0] = 5'b10000; vp[0] = 9'h080;  // -8 * -16 = 128
        va[1] = 4'b1000; vb[1] = 5'b01111; vp[1] = 9'h188;  // -8 * 15 = -120
        va[2] = 4'b1101; vb[2] = 5'b00111; vp[2] = 9'h1EB;  // -3 * 7 = -21
        va[3] = 4'b0111; vb[3] = 5'b00000; vp[3] = 9'h000;  // 7 * 0 = 0
        va[4] = 4'b0111; vb[4] = 5'b10000; vp[4] = 9'h190;  // 7 * -16 = -112
        va[5] = 4'b1111; vb[5] = 5'b00001; vp[5] = 9'h1FF;  // -1 * 1 = -1
        va[6] = 4'b1000; vb[6] = 5'b11111; vp[6] = 9'h008;  // -8 * -1 = 8
        va[7] = 4'b1000; vb[7] = 5'b00000; vp[7] = 9'h000;  // -8 * 0 = 0
        for (int i = 0; i < 8; i++) begin
            launch(va[i], vb[i]);
            wait_done(1, exp_lat(vb[i]), vp[i], $sformatf("vec%0d", i));
            check_idle_after(vp[i], $sformatf("vec%0d", i));
        end
    endtask

    task automatic test_ignore_start();
        launch(4'd2, 5'd3);
        tick();
        tick();
        start = 1'b1;
        A = 4'd5;
        B = 5'd5;
        tick();
        start = 1'b0;
        wait_done(4, exp_lat(5'd3), 9'h006, "ignore_busy_start");
        check_idle_after(9'h006, "ignore_busy_start");
    endtask

    task automatic test_back_to_back();
        launch(4'd3, 5'd5);
        wait_done(1, exp_lat(5'd5), 9'h00F, "b2b_first");
        launch(4'b1111, 5'b11111);
        wait_done(1, exp_lat(5'b11111), 9'h001, "b2b_second");
        check_idle_after(9'h001, "b2b_second");
    endtask

    task automatic test_reset_mid();
        launch(4'd3, 5'd5);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || Prod !== 9'h000) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b prod=%h want 0 0 000", busy, done, Prod);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet: got done=%b busy=%b want 0 0", done, busy);
            end
        end
        launch(4'b1101, 5'b00111);
        wait_done(1, exp_lat(5'b00111), 9'h1EB, "after_reset");
        check_idle_after(9'h1EB, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_nm_seq_ctrl.md
Name: mult_nm_seq_ctrl

Overview:
- Sequential signed N×M multiplier controller.
- Accepts one operand pair per start pulse and converts both operands to magnitude.
- Runs an iterative shift-add over the magnitude bits of B, then applies the sign fix-up.
- Reuses a single N-bit adder in place of the M-1 ripple-carry stages of the combinational array. Intended for area-constrained paths where multi-cycle latency is acceptable.

Parameters:
- N, 4, width of signed operand A (two's complement)
- M, 5, width of signed operand B (two's complement)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only when busy=0
- A  in  N  signed multiplicand, captured on accepted start
- B  in  M  signed multiplier, captured on accepted start
- busy  out  1  high while an operation is in progress (RUN, SIGN)
- done  out  1  single-cycle pulse; Prod is valid this cycle
- Prod  out  N+M  signed product, held until the next completion or reset

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - Reset values: state=IDLE, busy=0, done=0, Prod=0, accumulator=0, counter=0.
- States: IDLE, RUN, SIGN, DONE.
- IDLE:
  - start=1 → capture |A| (N bits unsigned), |B| (M bits unsigned) and neg = A[N-1]^B[M-1].
  - Clear the accumulator and load counter=M. Go to RUN.
  - Magnitude = ~x+1 when the MSB is set, else x.
  - The most negative value maps to 2^(N-1) (resp. 2^(M-1)). This is legal unsigned and must not overflow.
- RUN, one bit of |B| per cycle, LSB first:
  - If the current bit is 1, add |A| into the upper N bits of the accumulator; the carry goes into a carry bit.
  - Shift the accumulator right by 1 and shift the multiplier register right by 1.
  - Decrement the counter. When the counter reaches 1 in RUN, the next state is SIGN.
- SIGN:
  - Prod_next = neg ? (~acc+1) : acc, at full N+M width. Go to DONE.
  - Negation of 0 yields 0; no negative-zero special case.
- DONE: register Prod, done=1 for exactly this cycle. Next state is IDLE, or RUN if start=1 this cycle (back-to-back accepted).
- Handshake:
  - busy=0 in IDLE and DONE; start is accepted only then.
  - start while busy=1 is ignored, with no queuing and no effect on the running operation.
  - Operand inputs are don't-care except in the accept cycle.
- Fixed latency: start accepted at cycle t → done=1 at cycle t+M+2 (M RUN cycles, 1 SIGN, 1 DONE).
- Width rule: |product| ≤ 2^(N+M-2), so the signed N+M result never overflows. Full range holds for all operand combinations.
- Reset mid-operation: abort immediately, discard the partial result, and clear Prod to 0. No done pulse.
- Prod changes only in the DONE cycle or on reset.

Optional Feature:
- Macro: MULT_NM_EARLY_TERM_EN.
- Defined:
  - RUN exits to SIGN once the post-shift multiplier register is all zeros.
  - The accumulator is first aligned by the remaining shift count using a single barrel shift in SIGN.
  - Latency becomes t+k+2, where k = index of the highest set bit of |B| plus 1, minimum 1.
  - |B|=0 takes one RUN cycle.
  - Results are identical to the fixed-latency build.
- Undefined: fixed latency M+2 as above.

Test Plan:
- A=4'b0011 (3), B=5'b00101 (5), start at t=0 → busy high t+1..t+6, done at t+7, Prod=9'h00F (15); Prod held after done.
- A=4'b1000 (-8), B=5'b10000 (-16) → Prod=9'h080 (+128). A=4'b1000, B=5'b01111 (15) → Prod=9'h188 (-120).
- A=4'b1101 (-3), B=5'b00111 (7) → Prod=9'h1EB (-21). A=4'b0111, B=5'b00000 → Prod=9'h000, neg computed but result 0.
- Start A=2, B=3; pulse start again with A=5, B=5 at t+3 → ignored, done at t+7 with Prod=6. Start asserted in the DONE cycle with A=-1, B=-1 → accepted, done 7 cycles later, Prod=1.
- rst=1 at t+4 of an operation → next cycle state=IDLE, busy=0, Prod=0, no done pulse; a new start after rst is released completes normally.
- With MULT_NM_EARLY_TERM_EN: A=3, B=1 → done at t+3, Prod=3. A=-8, B=-16 → done at t+7, Prod=9'h080.
